life_game_step_controller: RTL

- Sequencer and bus arbiter for the life-game map memory device on its 7-bit block bus.
- Computes one Conway generation in place on the currently displayed buffer, using a rolling three-row window.
- Shares the block bus with the CPU; the CPU gets a stall signal while a step runs.
- A step is triggered by an explicit request, or automatically every N video frames.

---
 rtl/life_game_pkg.sv | 23 ++
 rtl/life_game_step_controller_if.sv | 34 +++
 rtl/life_game_row_rule.sv | 32 +++
 rtl/life_game_step_controller.sv | 131 +++++++++++++
 4 files changed

// File: rtl/life_game_pkg.sv
// Shared constants, row type and step-sequencer states for the life-game map
// memory step controller.
package life_game_pkg;

   localparam int BLOCK_COUNT_X = 64;
   localparam int BLOCK_COUNT_Y = 48;
   localparam int WORDS_PER_ROW = 2;
   localparam logic [6:0] ADDRESS_MAP_INDEX = 7'h7F;

   typedef logic [BLOCK_COUNT_X-1:0] row_t;

   typedef enum logic [2:0] {
      IDLE,
      PRIME0,
      PRIME1,
      READ0,
      READ1,
      WRITE0,
      WRITE1,
      DONE
   } step_state_t;

endpackage

// File: rtl/life_game_step_controller_if.sv
// CPU-side and device-side block bus, plus step control and status signals.
interface life_game_step_controller_if;

   logic        cpu_request;
   logic        cpu_write;
   logic [6:0]  cpu_address;
   logic [31:0] cpu_data_in;
   logic [31:0] cpu_data_out;
   logic        cpu_ready;
   logic        step_request;
   logic        auto_enable;
   logic        frame_tick;
   logic        block_write;
   logic [6:0]  block_address;
   logic [31:0] block_data_in;
   logic [31:0] block_data_out;
   logic        busy;
   logic [15:0] generation;

   modport slave (
      input  cpu_request, cpu_write, cpu_address, cpu_data_in,
      input  step_request, auto_enable, frame_tick, block_data_out,
      output cpu_data_out, cpu_ready, block_write, block_address,
      output block_data_in, busy, generation
   );

   modport master (
      output cpu_request, cpu_write, cpu_address, cpu_data_in,
      output step_request, auto_enable, frame_tick, block_data_out,
      input  cpu_data_out, cpu_ready, block_write, block_address,
      input  block_data_in, busy, generation
   );

endinterface

// File: rtl/life_game_row_rule.sv
// Combinational Conway rule for one row, given the rows above and below.
// Cells beyond either end of the row are dead.
module life_game_row_rule
   import life_game_pkg::*;
(
   input  row_t prev_row,
   input  row_t cur_row,
   input  row_t next_row,
   output row_t new_row
);

   // One dead guard cell at each end removes the edge special cases.
   logic [BLOCK_COUNT_X+1:0] prev_pad, cur_pad, next_pad;
   logic [3:0] neighbours;

   assign prev_pad = {1'b0, prev_row, 1'b0};
   assign cur_pad  = {1'b0, cur_row,  1'b0};
   assign next_pad = {1'b0, next_row, 1'b0};

   always_comb begin
      // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
      new_row    = '0;
      neighbours = '0;
      for (int x = 0; x < BLOCK_COUNT_X; x++) begin
         neighbours = 4'(prev_pad[x]) + 4'(prev_pad[x+1]) + 4'(prev_pad[x+2])
                    + 4'(cur_pad[x])                      + 4'(cur_pad[x+2])
                    + 4'(next_pad[x]) + 4'(next_pad[x+1]) + 4'(next_pad[x+2]);
         new_row[x] = (neighbours == 4'd3) || (cur_pad[x+1] && neighbours == 4'd2);
      end
   end

endmodule

// File: rtl/life_game_step_controller.sv
// Step sequencer and block-bus arbiter: computes one generation in place using a
// rolling prev/cur/next row window, and hands the bus to the CPU while idle.
module life_game_step_controller
   import life_game_pkg::*;
#(
   parameter int FRAMES_PER_STEP = 8
) (
   input logic clock,
   input logic reset_n,
   life_game_step_controller_if.slave bus
);

   localparam logic [5:0] LAST_ROW   = 6'(BLOCK_COUNT_Y - 1);
   localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_STEP - 1);

   step_state_t state;
   logic [5:0]  row_y;
   row_t        prev_row, cur_row, next_row, new_row;
   logic        pending;
   logic [7:0]  frame_count;
   logic [15:0] generation_q;
   logic        busy_q;

   logic        last_row, auto_trigger, trigger;
   logic        engine_write;
   logic [6:0]  engine_address;
   logic [31:0] engine_data;

   assign last_row     = (row_y == LAST_ROW);
   assign auto_trigger = bus.auto_enable && bus.frame_tick && (frame_count == FRAME_LAST);
   assign trigger      = bus.step_request || auto_trigger;

   life_game_row_rule u_row_rule (
      .prev_row (prev_row),
      .cur_row  (cur_row),
      .next_row (next_row),
      .new_row  (new_row)
   );

   always_comb begin
      engine_write   = 1'b0;
      engine_address = '0;
      engine_data    = '0;
      case (state)
         PRIME1: engine_address = {6'd0, 1'b1};
         READ0:  if (!last_row) engine_address = {row_y + 6'd1, 1'b0};
         READ1:  if (!last_row) engine_address = {row_y + 6'd1, 1'b1};
         WRITE0: begin
            engine_write   = 1'b1;
            engine_address = {row_y, 1'b0};
            engine_data    = new_row[31:0];
         end
         WRITE1: begin
            engine_write   = 1'b1;
            engine_address = {row_y, 1'b1};
            engine_data    = new_row[63:32];
         end
         default: ;
      endcase
   end

   assign bus.block_write   = (state == IDLE) ? (bus.cpu_request && bus.cpu_write) : engine_write;
   assign bus.block_address = (state == IDLE) ? (bus.cpu_request ? bus.cpu_address : '0) : engine_address;
   assign bus.block_data_in = (state == IDLE) ? (bus.cpu_request ? bus.cpu_data_in : '0) : engine_data;
   assign bus.cpu_ready     = (state == IDLE);
   assign bus.cpu_data_out  = bus.block_data_out;
   assign bus.busy          = busy_q;
   assign bus.generation    = generation_q;

   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
      if (!reset_n) begin
         state        <= IDLE;
         row_y        <= '0;
         prev_row     <= '0;
         cur_row      <= '0;
         next_row     <= '0;
         pending      <= 1'b0;
         frame_count  <= '0;
         generation_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         if (!bus.auto_enable)
            frame_count <= '0;
         else if (bus.frame_tick)
            frame_count <= auto_trigger ? 8'd0 : frame_count + 8'd1;

         // Triggers collapse; one arriving on the start cycle is kept for the next step.
         pending <= trigger || (pending && state != IDLE);

         case (state)
            IDLE: if (pending) begin
               state    <= PRIME0;
               busy_q   <= 1'b1;
               row_y    <= '0;
               prev_row <= '0;
            end
            PRIME0: begin
               cur_row[31:0] <= bus.block_data_out;
               state         <= PRIME1;
            end
            PRIME1: begin
               cur_row[63:32] <= bus.block_data_out;
               state          <= READ0;
            end
            READ0: begin
               next_row[31:0] <= last_row ? 32'd0 : bus.block_data_out;
               state          <= READ1;
            end
            READ1: begin
               next_row[63:32] <= last_row ? 32'd0 : bus.block_data_out;
               state           <= WRITE0;
            end
            WRITE0: state <= WRITE1;
            WRITE1: begin
               prev_row <= cur_row;
               cur_row  <= next_row;
               row_y    <= row_y + 6'd1;
               state    <= last_row ? DONE : READ0;
            end
            DONE: begin
               generation_q <= generation_q + 16'd1;
               busy_q       <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
